// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial add/subtract engine. A single full-adder cell (two half adders and
// an OR for the carry) is reused across all WIDTH bit positions, one bit per
// clock, LSB first. Operands enter through a valid/ready handshake. The result
// leaves through a second valid/ready handshake.
//
// Subtraction is A + ~B + 1. The inverted B and the forced carry-in of 1 are
// loaded at accept time, so the RUN datapath is the same for both operations.
//
// Parameters:
//   WIDTH        operand/result width in bits (1..64)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active-low
//   i_in_valid   operands and op presented
//   o_in_ready   block can accept operands this cycle (combinational)
//   i_a, i_b     operands A and B
//   i_cin        carry-in, ignored when i_op_sub=1
//   i_op_sub     0: A+B+cin, 1: A-B
//   o_out_valid  result held valid (DONE state)
//   i_out_ready  consumer takes the result
//   o_sum        result bits, registered, held until the next result
//   o_cout       final carry; in subtract mode 1 means no borrow
//   o_busy       high while bits are being processed (RUN state)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_op_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            r_state;
  state_e            w_state_d;

  logic [WIDTH-1:0]  r_a_sh;
  logic [WIDTH-1:0]  r_b_sh;
  logic [WIDTH-1:0]  r_s_sh;
  logic              r_c;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;

  logic              w_accept;
  logic              w_shift;
  logic              w_last;

  // Shared full-adder cell built from two half adders.
  logic              w_ha0_s;
  logic              w_ha0_c;
  logic              w_ha1_s;
  logic              w_ha1_c;
  logic              w_carry;
  logic [WIDTH-1:0]  w_s_next;

  assign w_ha0_s = r_a_sh[0] ^ r_b_sh[0];
  assign w_ha0_c = r_a_sh[0] & r_b_sh[0];
  assign w_ha1_s = w_ha0_s ^ r_c;
  assign w_ha1_c = w_ha0_s & r_c;
  assign w_carry = w_ha0_c | w_ha1_c;

  // Result bits enter at the MSB and move down, so after WIDTH shifts bit 0
  // of the result sits at bit 0 of the register.
  if (WIDTH == 1) begin : g_s_w1
    assign w_s_next = w_ha1_s;
  end else begin : g_s_wn
    assign w_s_next = {w_ha1_s, r_s_sh[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Handshake and status outputs
  // ---------------------------------------------------------------------------
  // DONE with out_ready lets a new operation start on the same edge that
  // consumes the result, so there is no bubble between back-to-back ops.
  assign o_in_ready  = (r_state == StIdle) | ((r_state == StDone) & i_out_ready);
  assign w_accept    = i_in_valid & o_in_ready;
  assign o_out_valid = (r_state == StDone);
  assign o_busy      = (r_state == StRun);
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    w_shift   = 1'b0;
    w_last    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_shift = 1'b1;
        if (r_cnt == CntLast) begin
          w_last    = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (i_out_ready) begin
          w_state_d = i_in_valid ? StRun : StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry, bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_s_sh <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= i_a;
      r_b_sh <= i_op_sub ? ~i_b : i_b;
      r_c    <= i_op_sub ? 1'b1 : i_cin;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_s_sh <= w_s_next;
      r_c    <= w_carry;
      r_cnt  <= r_cnt + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: captured on the last RUN edge and held until the next
  // result, independent of the shifters that restart on a new accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_s_next;
      r_cout <= w_carry;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl. Instantiates a WIDTH=8 and a WIDTH=1
// copy sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  // WIDTH=8 instance
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       op_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  // WIDTH=1 instance
  logic       u1_in_valid;
  logic       u1_in_ready;
  logic [0:0] u1_a;
  logic [0:0] u1_b;
  logic       u1_cin;
  logic       u1_op_sub;
  logic       u1_out_valid;
  logic       u1_out_ready;
  logic [0:0] u1_sum;
  logic       u1_cout;
  logic       u1_busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_cin       (cin),
    .i_op_sub    (op_sub),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sum       (sum),
    .o_cout      (cout),
    .o_busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (u1_in_valid),
    .o_in_ready  (u1_in_ready),
    .i_a         (u1_a),
    .i_b         (u1_b),
    .i_cin       (u1_cin),
    .i_op_sub    (u1_op_sub),
    .o_out_valid (u1_out_valid),
    .i_out_ready (u1_out_ready),
    .o_sum       (u1_sum),
    .o_cout      (u1_cout),
    .o_busy      (u1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
    logic [8:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + 9'd1;
    else   r = {1'b0, x} + {1'b0, y} + {8'd0, c};
    return r;
  endfunction

  // Wait (bounded) for out_valid; returns edges taken.
  task automatic wait_result(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  // One complete operation with out_ready held high.
  task automatic do_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                       input logic xc, input logic xs,
                       input logic [7:0] es, input logic ec);
    int lat;
    int bc;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    a = xa; b = xb; cin = xc; op_sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, busy, 1'b1);
    wait_result(lat, bc);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    step();
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_sum_held"}, sum, es);
  endtask

  initial begin
    int         lat;
    int         bc;
    logic [8:0] r;
    logic [7:0] exp_s;
    logic       exp_c;
    logic [7:0] ra, rb;
    logic       rc, rs;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
    u1_in_valid = 1'b0; u1_a = '0; u1_b = '0; u1_cin = 1'b0; u1_op_sub = 1'b0;
    u1_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    step();

    // Basic add and subtract cases
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    do_op("sub_5_7",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    do_op("sub_7_5",   8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
    do_op("sub_3c_3c", 8'h3C, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b1);
    do_op("add_cin",   8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0);

    // Backpressure: result held while out_ready=0 and in_valid stays high
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    step();
    a = 8'h80; b = 8'h80; cin = 1'b0; op_sub = 1'b0;
    wait_result(lat, bc);
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_sum", sum, 8'h46);
      chk("bp_cout", cout, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rise", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_consume_valid", out_valid, 1'b0);
    chk("bp_second_busy", busy, 1'b1);
    wait_result(lat, bc);
    chk("bp2_latency", lat, 8);
    chk("bp2_sum", sum, 8'h00);
    chk("bp2_cout", cout, 1'b1);
    step();

    // Back-to-back: in_valid and out_ready held high, 16 random operations
    out_ready = 1'b1;
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    a = ra; b = rb; cin = rc; op_sub = rs; in_valid = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      r = ref_op(ra, rb, rc, rs);
      exp_s = r[7:0];
      exp_c = r[8];
      wait_result(lat, bc);
      chk("b2b_latency", lat, 8);
      chk("b2b_sum", sum, exp_s);
      chk("b2b_cout", cout, exp_c);
      if (i < 15) begin
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        a = ra; b = rb; cin = rc; op_sub = rs;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i < 15) chk("b2b_no_bubble", busy, 1'b1);
    end
    chk("b2b_idle", in_ready, 1'b1);

    // Reset in the middle of RUN
    a = 8'hAA; b = 8'h55; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("mid_busy_before", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_sum", sum, 8'h00);
    chk("mid_cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_in_ready", in_ready, 1'b1);
    do_op("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);

    // WIDTH=1 instance
    u1_out_ready = 1'b1;
    u1_a = 1'b1; u1_b = 1'b1; u1_cin = 1'b1; u1_op_sub = 1'b0; u1_in_valid = 1'b1;
    chk("w1_in_ready", u1_in_ready, 1'b1);
    step();
    u1_in_valid = 1'b0;
    chk("w1_busy", u1_busy, 1'b1);
    chk("w1_valid_early", u1_out_valid, 1'b0);
    step();
    chk("w1_out_valid", u1_out_valid, 1'b1);
    chk("w1_sum", u1_sum, 1'b1);
    chk("w1_cout", u1_cout, 1'b1);
    step();
    chk("w1_consumed", u1_out_valid, 1'b0);
    u1_a = 1'b0; u1_b = 1'b1; u1_cin = 1'b0; u1_op_sub = 1'b1; u1_in_valid = 1'b1;
    step();
    u1_in_valid = 1'b0;
    step();
    chk("w1_sub_valid", u1_out_valid, 1'b1);
    chk("w1_sub_sum", u1_sum, 1'b1);
    chk("w1_sub_cout", u1_cout, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
